// File: rtl/detect_event_logger_if.sv
// Host-side bundle for the detection event logger: detector input, control, FIFO read
// handshake and monitoring outputs.
interface detect_event_logger_if #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

    logic              det_in;
    logic              enable;
    logic              clear;
    logic              ts_ready;
    logic [TS_W-1:0]   ts_data;
    logic              ts_valid;
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  det_count;
    logic              overflow;

    modport master (
        output det_in, enable, clear, ts_ready,
        input  ts_data, ts_valid, fill, det_count, overflow
    );

    modport slave (
        input  det_in, enable, clear, ts_ready,
        output ts_data, ts_valid, fill, det_count, overflow
    );
endinterface

// File: rtl/detect_event_logger.sv
// Timestamps each 101010 detector pulse into a small first-word fall-through FIFO, with a
// saturating detection counter and a sticky overflow flag.
module detect_event_logger #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    detect_event_logger_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_PART  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [TS_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FILL_W-1:0] r_fill;
    logic [TS_W-1:0]   r_ts;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;

    logic [1:0] w_state;
    logic       w_push_req;
    logic       w_push;
    logic       w_pop;
    logic       w_drop;

    // FIFO state is a pure decode of the fill register.
    always_comb begin
        w_state = ST_PART;
        if (r_fill == '0) begin
            w_state = ST_EMPTY;
        end else if (r_fill == FILL_W'(DEPTH)) begin
            w_state = ST_FULL;
        end
    end

    assign w_push_req = bus.enable & bus.det_in;
    assign w_pop      = (w_state != ST_EMPTY) & bus.ts_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push     = w_push_req & ((w_state != ST_FULL) | w_pop);
    assign w_drop     = w_push_req & (w_state == ST_FULL) & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_ts     <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_ts     <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (bus.enable) begin
                r_ts <= r_ts + TS_W'(1);
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_ts;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + FILL_W'(1);
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - FILL_W'(1);
            end
            if (w_push_req && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.ts_data   = r_mem[r_rd_ptr];
    assign bus.ts_valid  = (w_state != ST_EMPTY);
    assign bus.fill      = r_fill;
    assign bus.det_count = r_cnt;
    assign bus.overflow  = r_ovf;
endmodule
